// File: rtl/fetch_unit.sv
// Instruction-fetch sequencer: owns the fetch PC, drives the combinational
// imem, and queues {pc, instr} pairs in an in-order buffer for decode.
// A redirect from execute flushes the buffer and restarts fetch at the
// target address.
// Optional build macro FETCH_ALIGN_CHK_EN: a misaligned redirect target
// enters a sticky FAULT state (fault_o=1) that only rst_ni can clear.
// When the macro is undefined, the low two target bits are ignored.
module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int unsigned BUF_DEPTH = 2
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        fetch_en_i,
  output logic [31:0] imem_addr_o,
  input  logic [31:0] imem_instr_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        instr_valid_o,
  input  logic        instr_ready_i,
  output logic [31:0] instr_o,
  output logic [31:0] pc_o,
  output logic        fault_o
);

  localparam int unsigned PW = $clog2(BUF_DEPTH);
  localparam logic [PW:0] DEPTH_C = (PW+1)'(BUF_DEPTH);

`ifdef FETCH_ALIGN_CHK_EN
  typedef enum logic [1:0] {IDLE, RUN, FAULT} state_t;
`else
  typedef enum logic [1:0] {IDLE, RUN} state_t;
`endif

  state_t        state_q, state_d;
  logic [31:0]   fetch_pc_q;
  logic [PW:0]   count_q;
  logic [PW-1:0] rd_ptr_q, wr_ptr_q;
  logic [31:0]   pc_mem    [BUF_DEPTH];
  logic [31:0]   instr_mem [BUF_DEPTH];

  logic          redir;
  logic          misalign;
  logic [31:0]   redir_target;
  logic          push;
  logic          pop;
  logic          valid;

  // Next-state logic plus the push/pop/redirect handshake decisions.
  always_comb begin
    state_d      = state_q;
    redir        = redirect_i;
    misalign     = 1'b0;
    redir_target = redirect_pc_i & 32'hFFFF_FFFC;
    valid        = 1'b0;
    push         = 1'b0;
    pop          = 1'b0;
`ifdef FETCH_ALIGN_CHK_EN
    // Redirects are ignored once faulted; a misaligned target faults.
    redir    = redirect_i & (state_q != FAULT);
    misalign = redir & (redirect_pc_i[1:0] != 2'b00);
`endif
    valid = (count_q != '0) & ~redir;
`ifdef FETCH_ALIGN_CHK_EN
    valid = valid & (state_q != FAULT);
`endif
    push = (state_q == RUN) & (count_q < DEPTH_C) & ~redir;
    pop  = valid & instr_ready_i;
    if (misalign) begin
      state_d = state_t'(2);
    end else if (!redir) begin
      case (state_q)
        IDLE:    if (fetch_en_i)  state_d = RUN;
        RUN:     if (!fetch_en_i) state_d = IDLE;
        default: state_d = state_q;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Fetch PC, occupancy and pointers; redirect wins over push/pop.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      fetch_pc_q <= RESET_PC;
      count_q    <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
    end else if (redir) begin
      count_q  <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      if (!misalign) fetch_pc_q <= redir_target;
    end else begin
      if (push) begin
        wr_ptr_q   <= wr_ptr_q + 1'b1;
        fetch_pc_q <= fetch_pc_q + 32'd4;
      end
      if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      if (push && !pop)      count_q <= count_q + 1'b1;
      else if (pop && !push) count_q <= count_q - 1'b1;
    end
  end

  // Buffer storage; contents are only meaningful while counted valid.
  always_ff @(posedge clk_i) begin
    if (push) begin
      pc_mem[wr_ptr_q]    <= fetch_pc_q;
      instr_mem[wr_ptr_q] <= imem_instr_i;
    end
  end

  assign imem_addr_o   = fetch_pc_q;
  assign instr_valid_o = valid;
  assign instr_o       = (count_q != '0) ? instr_mem[rd_ptr_q] : '0;
  assign pc_o          = (count_q != '0) ? pc_mem[rd_ptr_q]    : '0;
`ifdef FETCH_ALIGN_CHK_EN
  assign fault_o = (state_q == FAULT);
`else
  assign fault_o = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: the driver issues stimulus, advances a
// queue-based reference model and pushes the expected per-cycle view; a
// monitor on the falling edge pops and compares.
module tb_fetch_unit;

  localparam int unsigned DEPTH = 2;
  localparam logic [31:0] RPC   = 32'h0000_0000;
`ifdef FETCH_ALIGN_CHK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        fetch_en;
  logic [31:0] imem_addr;
  logic [31:0] imem_instr;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] pc;
  logic        fault;

  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(RPC), .BUF_DEPTH(DEPTH)) dut (
    .clk_i(clk), .rst_ni(rst_n), .fetch_en_i(fetch_en),
    .imem_addr_o(imem_addr), .imem_instr_i(imem_instr),
    .redirect_i(redirect), .redirect_pc_i(redirect_pc),
    .instr_valid_o(instr_valid), .instr_ready_i(instr_ready),
    .instr_o(instr), .pc_o(pc), .fault_o(fault)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  assign imem_instr = mem_word(imem_addr);

  typedef struct {
    bit          valid;
    bit          empty;
    logic [31:0] pc;
    logic [31:0] ins;
    logic [31:0] addr;
    bit          fault;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] mq_pc[$];
  logic [31:0] mq_ins[$];
  logic [31:0] m_pc;
  bit          m_run;
  bit          m_fault;
  int          passed = 0;
  int          total  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act === expv) passed++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
  endtask

  // Called just after a rising edge: apply inputs, record what the DUT must
  // show this cycle, then advance the model across the next edge.
  task automatic step(input bit en, input bit redir, input logic [31:0] rpc, input bit rdy);
    exp_t e;
    bit   red_eff;
    int   occ;
    fetch_en    = en;
    redirect    = redir;
    redirect_pc = rpc;
    instr_ready = rdy;
    red_eff = redir && !m_fault;
    e.empty = (mq_pc.size() == 0);
    e.valid = !e.empty && !red_eff && !m_fault;
    e.pc    = e.empty ? 32'h0 : mq_pc[0];
    e.ins   = e.empty ? 32'h0 : mq_ins[0];
    e.addr  = m_pc;
    e.fault = m_fault;
    exp_q.push_back(e);
    if (red_eff) begin
      mq_pc.delete();
      mq_ins.delete();
      if (CHK && rpc[1:0] != 2'b00) m_fault = 1'b1;
      else m_pc = {rpc[31:2], 2'b00};
    end else if (!m_fault) begin
      occ = mq_pc.size();
      if (e.valid && rdy) begin
        void'(mq_pc.pop_front());
        void'(mq_ins.pop_front());
      end
      if (m_run && occ < DEPTH) begin
        mq_pc.push_back(m_pc);
        mq_ins.push_back(mem_word(m_pc));
        m_pc = m_pc + 32'd4;
      end
      m_run = en;
    end
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    fetch_en    = 1'b0;
    redirect    = 1'b0;
    redirect_pc = '0;
    instr_ready = 1'b0;
    rst_n       = 1'b0;
    exp_q.delete();
    mq_pc.delete();
    mq_ins.delete();
    m_pc    = RPC;
    m_run   = 1'b0;
    m_fault = 1'b0;
    #1;
    chk("rst_valid", {31'b0, instr_valid}, 32'h0);
    chk("rst_instr", instr, 32'h0);
    chk("rst_pc",    pc, 32'h0);
    chk("rst_fault", {31'b0, fault}, 32'h0);
    chk("rst_addr",  imem_addr, RPC);
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  // Monitor: compare the DUT against the expected view for this cycle.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n === 1'b1 && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("valid", {31'b0, instr_valid}, {31'b0, e.valid});
      chk("addr",  imem_addr, e.addr);
      chk("fault", {31'b0, fault}, {31'b0, e.fault});
      if (e.valid || e.empty) begin
        chk("head_pc",    pc, e.pc);
        chk("head_instr", instr, e.ins);
      end
    end
  end

  initial begin
    logic [31:0] r;
    do_reset();
    // Straight-line fetch with decode always ready.
    repeat (6) step(1, 0, 0, 1);
    // Back-pressure: buffer saturates, then drains in order.
    do_reset();
    repeat (6) step(1, 0, 0, 0);
    repeat (5) step(1, 0, 0, 1);
    // Redirect while full.
    do_reset();
    repeat (4) step(1, 0, 0, 0);
    step(1, 1, 32'h20, 0);
    repeat (4) step(1, 0, 0, 1);
    // Redirect while the head is being offered with ready high.
    do_reset();
    repeat (3) step(1, 0, 0, 1);
    step(1, 1, 32'h100, 1);
    repeat (4) step(1, 0, 0, 1);
    // Wrap-around at the top of the address space.
    step(1, 1, 32'hFFFF_FFFC, 1);
    repeat (4) step(1, 0, 0, 1);
    // Fetch disabled with a full buffer: drains, then address freezes.
    repeat (4) step(1, 0, 0, 0);
    repeat (5) step(0, 0, 0, 1);
    if (!CHK) begin
      // Low target bits are ignored without the alignment check.
      step(1, 1, 32'h22, 1);
      repeat (4) step(1, 0, 0, 1);
    end
    // Randomized traffic.
    for (int i = 0; i < 2000; i++) begin
      r = $urandom;
      if (CHK) r = r & 32'hFFFF_FFFC;
      step($urandom_range(0, 9) != 0, $urandom_range(0, 19) == 0, r, $urandom_range(0, 1) == 1);
    end
`ifdef FETCH_ALIGN_CHK_EN
    do_reset();
    repeat (3) step(1, 0, 0, 1);
    step(1, 1, 32'h22, 1);
    repeat (3) step(1, 0, 0, 1);
    step(1, 1, 32'h40, 1);
    repeat (3) step(1, 0, 0, 1);
    do_reset();
    repeat (4) step(1, 0, 0, 1);
`endif
    @(negedge clk);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
